trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: synchronizes interrupt lines into mip, arbitrates
// exceptions against interrupts, and sequences trap entry / handler / mret.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        sw_irq,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        inst_boundary,
  input  logic        trap_finish,
  input  logic [31:0] mie,
  input  logic        irq_en,
  output logic [31:0] mip,
  output logic [31:0] trap_cause,
  output logic        trap_pending,
  output logic        in_trap
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned MEI_BIT = 11;
  localparam int unsigned MTI_BIT = 7;
  localparam int unsigned MSI_BIT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    IN_TRAP = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [SYNC_STAGES-1:0] tmr_sync;
  logic [SYNC_STAGES-1:0] sw_sync;
  logic [XLEN-1:0]        pend;
  logic                   irq_req;
  logic [CODE_W-1:0]      irq_code;
  logic [XLEN-1:0]        exc_cause;
  logic [XLEN-1:0]        irq_cause;

  // Interrupt level synchronizers; mip is driven straight from the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync <= '0;
      tmr_sync <= '0;
      sw_sync  <= '0;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
      tmr_sync <= {tmr_sync[SYNC_STAGES-2:0], tmr_irq};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0],  sw_irq};
    end
  end

  always_comb begin
    mip          = '0;
    mip[MEI_BIT] = ext_sync[SYNC_STAGES-1];
    mip[MTI_BIT] = tmr_sync[SYNC_STAGES-1];
    mip[MSI_BIT] = sw_sync[SYNC_STAGES-1];
  end

  assign pend    = mip & mie;
  assign irq_req = irq_en & (|pend);

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    irq_code = CODE_W'(MTI_BIT);
    if (pend[MEI_BIT]) begin
      irq_code = CODE_W'(MEI_BIT);
    end else if (pend[MSI_BIT]) begin
      irq_code = CODE_W'(MSI_BIT);
    end
  end

  assign exc_cause = {1'b0, 26'b0, exc_code};
  assign irq_cause = {1'b1, 26'b0, irq_code};

  // Trap sequencing; trap_pending and in_trap track ENTER and IN_TRAP exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      trap_cause   <= '0;
      trap_pending <= 1'b0;
      in_trap      <= 1'b0;
    end else begin
      trap_pending <= 1'b0;
      case (state)
        IDLE: begin
          in_trap <= 1'b0;
          if (exc_valid) begin
            state        <= ENTER;
            trap_cause   <= exc_cause;
            trap_pending <= 1'b1;
          end else if (irq_req && inst_boundary) begin
            state        <= ENTER;
            trap_cause   <= irq_cause;
            trap_pending <= 1'b1;
          end
        end
        ENTER: begin
          state   <= IN_TRAP;
          in_trap <= 1'b1;
        end
        IN_TRAP: begin
          if (exc_valid) begin
            state        <= ENTER;
            trap_cause   <= exc_cause;
            trap_pending <= 1'b1;
            in_trap      <= 1'b0;
          end else if (trap_finish) begin
            state   <= IDLE;
            in_trap <= 1'b0;
          end else begin
            in_trap <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          in_trap <= 1'b0;
        end
      endcase
    end
  end

endmodule
